// File: rtl/network.sv
// Leaky integrate-and-fire neuron: scans one pixel per clock, accumulates its
// weight into the membrane potential, leaks once per sweep, latches a sticky fire flag.
module network #(
  parameter int                         WIDTH   = 8,
  parameter int                         HEIGHT  = 7,
  parameter logic [HEIGHT-1:0][WIDTH:0] WEIGHTS = {HEIGHT{(WIDTH+1)'(60)}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HEIGHT-1:0] pixels,
  output logic              neuron_out
);

  localparam int IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int V_W   = WIDTH + 3;

  localparam logic [V_W-1:0]   THRESH = V_W'(2 ** (WIDTH + 2));
  localparam logic [V_W-1:0]   LEAK   = V_W'(2 ** WIDTH);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(HEIGHT - 1);

  logic [IDX_W-1:0] idx;
  logic [V_W-1:0]   v;
  logic             fired;

  logic [WIDTH:0]   syn;
  logic [V_W-1:0]   sum;
  logic             end_of_sweep;

  // V stays below THRESH + 2^(WIDTH+1), so the sum cannot wrap at V_W bits.
  always_comb begin
    syn          = pixels[idx] ? WEIGHTS[idx] : '0;
    sum          = v + V_W'(syn);
    end_of_sweep = (idx == LAST);
  end

  // NOTE: reset is sampled on the clock edge, so it is tested inside the
  // clocked block and outranks every other update, including a crossing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx   <= '0;
      v     <= '0;
      fired <= 1'b0;
    end else begin
      if (sum >= THRESH) begin
        v     <= '0;
        fired <= 1'b1;
      end else if (end_of_sweep) begin
        v <= (sum >= LEAK) ? sum - LEAK : '0;
      end else begin
        v <= sum;
      end
      idx <= end_of_sweep ? '0 : idx + IDX_W'(1);
    end
  end

  assign neuron_out = fired;

endmodule

// File: tb/tb_network.sv
// Directed bench for network: three instances (weights 260, 60 and 256) share
// clock, reset and pixels; each scenario resets all of them first.
module tb_network;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] pixels = '0;
  logic       out_a, out_b, out_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  network #(.WIDTH(8), .HEIGHT(7), .WEIGHTS({7{9'd260}})) dut_a (
    .clk(clk), .rst(rst), .pixels(pixels), .neuron_out(out_a));

  network #(.WIDTH(8), .HEIGHT(7)) dut_b (
    .clk(clk), .rst(rst), .pixels(pixels), .neuron_out(out_b));

  network #(.WIDTH(8), .HEIGHT(7), .WEIGHTS({7{9'd256}})) dut_c (
    .clk(clk), .rst(rst), .pixels(pixels), .neuron_out(out_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_all(input logic [6:0] pix);
    rst    = 1'b0;
    pixels = pix;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    int max_v;
    int any_out;

    // Reset with all pixels active
    step(1);
    reset_all(7'h7F);
    check("reset_out_a", 32'(out_a), 0);
    check("reset_v_a", 32'(dut_a.v), 0);
    check("reset_idx_a", 32'(dut_a.idx), 0);
    check("reset_out_b", 32'(out_b), 0);

    // Weights 260: crossing at the fourth pixel, then the sweep-end leak
    step(1);
    check("w260_v_e1", 32'(dut_a.v), 260);
    step(2);
    check("w260_v_e3", 32'(dut_a.v), 780);
    check("w260_out_e3", 32'(out_a), 0);
    step(1);
    check("w260_out_e4", 32'(out_a), 1);
    check("w260_v_e4", 32'(dut_a.v), 0);
    step(3);
    check("w260_v_e7", 32'(dut_a.v), 524);
    check("w260_idx_e7", 32'(dut_a.idx), 0);
    check("w260_out_e7", 32'(out_a), 1);
    step(20);
    check("w260_sticky", 32'(out_a), 1);

    // Weights 256: a sum of exactly T fires on edge 4
    reset_all(7'h7F);
    step(3);
    check("w256_v_e3", 32'(dut_c.v), 768);
    check("w256_out_e3", 32'(out_c), 0);
    step(1);
    check("w256_exact_t", 32'(out_c), 1);

    // Weights 256, only pixel 0: sweep-end sum of exactly L leaks to 0
    reset_all(7'h01);
    step(6);
    check("w256_v_e6", 32'(dut_c.v), 256);
    step(1);
    check("w256_exact_l", 32'(dut_c.v), 0);

    // Pixels other than pixels[idx] have no effect: only pixel 3 set,
    // it contributes on edge 4 and nowhere else in the sweep
    reset_all(7'h08);
    step(3);
    check("sel_v_e3", 32'(dut_a.v), 0);
    step(1);
    check("sel_v_e4", 32'(dut_a.v), 260);
    step(3);
    check("sel_v_e7", 32'(dut_a.v), 4);

    // Weights 260, no pixels: 7168 cycles without activity
    reset_all(7'h00);
    max_v   = 0;
    any_out = 0;
    for (int i = 0; i < 7168; i++) begin
      step(1);
      if (int'(dut_a.v) > max_v) max_v = int'(dut_a.v);
      if (out_a) any_out = 1;
    end
    check("idle_any_out", 32'(any_out), 0);
    check("idle_max_v", 32'(max_v), 0);

    // Default weights 60, all pixels: fire on edge 35
    reset_all(7'h7F);
    step(7);
    check("w60_sweep1", 32'(dut_b.v), 164);
    step(7);
    check("w60_sweep2", 32'(dut_b.v), 328);
    step(7);
    check("w60_sweep3", 32'(dut_b.v), 492);
    step(7);
    check("w60_sweep4", 32'(dut_b.v), 656);
    step(6);
    check("w60_out_e34", 32'(out_b), 0);
    check("w60_v_e34", 32'(dut_b.v), 1016);
    step(1);
    check("w60_out_e35", 32'(out_b), 1);
    check("w60_v_e35", 32'(dut_b.v), 0);

    // Default weights, only pixel 0: 60 leaks away every sweep
    reset_all(7'h01);
    any_out = 0;
    max_v   = 0;
    for (int i = 0; i < 7168; i++) begin
      step(1);
      if (int'(dut_b.v) > max_v) max_v = int'(dut_b.v);
      if (out_b) any_out = 1;
    end
    check("w60_px0_out", 32'(any_out), 0);
    check("w60_px0_max_v", 32'(max_v), 60);

    // Reset mid-operation on edge 3, fire four edges after release
    reset_all(7'h7F);
    step(2);
    check("mid_v_e2", 32'(dut_a.v), 520);
    rst = 1'b0;
    step(1);
    check("mid_v_rst", 32'(dut_a.v), 0);
    check("mid_idx_rst", 32'(dut_a.idx), 0);
    check("mid_out_rst", 32'(out_a), 0);
    rst = 1'b1;
    step(3);
    check("mid_out_e3", 32'(out_a), 0);
    step(1);
    check("mid_out_e4", 32'(out_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
